// File: rtl/hack_ctrl_decoder_pkg.sv
// -----------------------------------------------------------------------------
// hack_ctrl_decoder_pkg
// Shared definitions for the Hack control decoder slice:
//   - instruction bit-index localparams
//   - jump-code constants (JGT..JMP)
//   - decoder FSM state encoding
//   - decoded-entry struct plus decode / illegal-encoding helper functions
// No ports (package).
// -----------------------------------------------------------------------------
package hack_ctrl_decoder_pkg;

    // Instruction field positions
    localparam int I_CBIT    = 15;
    localparam int I_CC_HI   = 14;
    localparam int I_CC_LO   = 13;
    localparam int I_ABIT    = 12;
    localparam int I_ALU_HI  = 11;
    localparam int I_ALU_LO  = 6;
    localparam int I_DEST_HI = 5;
    localparam int I_DEST_LO = 3;
    localparam int I_JMP_HI  = 2;
    localparam int I_JMP_LO  = 0;

    // Jump codes (j1 j2 j3)
    localparam logic [2:0] JNULL = 3'b000;
    localparam logic [2:0] JGT   = 3'b001;
    localparam logic [2:0] JEQ   = 3'b010;
    localparam logic [2:0] JGE   = 3'b011;
    localparam logic [2:0] JLT   = 3'b100;
    localparam logic [2:0] JNE   = 3'b101;
    localparam logic [2:0] JLE   = 3'b110;
    localparam logic [2:0] JMP   = 3'b111;

    // EMPTY: no entry held; FULL: entry held; TRAP: illegal seen, intake closed
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_TRAP  = 2'b10
    } state_e;

    typedef struct packed {
        logic        is_a;
        logic [15:0] a_imm;
        logic        a_sel;
        logic [5:0]  alu;      // {zx,nx,zy,ny,f,no}
        logic        load_a;
        logic        load_d;
        logic        write_m;
        logic [2:0]  jcode;    // {j1,j2,j3}
    } dec_t;

    // Decode one instruction into the registered entry format.
    function automatic dec_t decode(input logic [15:0] ins);
        dec_t d;
        d = '0;
        if (ins[I_CBIT] == 1'b0) begin
            d.is_a   = 1'b1;
            d.load_a = 1'b1;
            d.a_imm  = {1'b0, ins[I_CC_HI:0]};
        end else begin
            d.a_sel   = ins[I_ABIT];
            d.alu     = ins[I_ALU_HI:I_ALU_LO];
            d.load_a  = ins[I_DEST_HI];
            d.load_d  = ins[I_DEST_HI-1];
            d.write_m = ins[I_DEST_LO];
            d.jcode   = ins[I_JMP_HI:I_JMP_LO];
        end
        return d;
    endfunction

    // C-instructions must carry 2'b11 in the two unused high bits.
    function automatic logic is_illegal(input logic [15:0] ins);
        return ins[I_CBIT] & (ins[I_CC_HI:I_CC_LO] != 2'b11);
    endfunction

endpackage

// File: rtl/hack_ctrl_decoder_if.sv
// -----------------------------------------------------------------------------
// hack_ctrl_decoder_if
// Bundles the decoder's upstream (instruction) and downstream (decoded
// controls + ALU flags) handshakes.
//   slave  : decoder side (accepts instr, produces controls/jump/trap)
//   master : environment side (fetch + ALU/register-file consumer)
// -----------------------------------------------------------------------------
interface hack_ctrl_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic        zx;
    logic        nx;
    logic        zy;
    logic        ny;
    logic        f;
    logic        no;
    logic        a_sel;
    logic        is_a_instr;
    logic [15:0] a_imm;
    logic        load_a;
    logic        load_d;
    logic        write_m;
    logic        alu_zr;
    logic        alu_ng;
    logic        jump;
    logic        trap;

    modport slave (
        input  in_valid, instr, out_ready, alu_zr, alu_ng,
        output in_ready, out_valid, zx, nx, zy, ny, f, no, a_sel, is_a_instr,
               a_imm, load_a, load_d, write_m, jump, trap
    );

    modport master (
        output in_valid, instr, out_ready, alu_zr, alu_ng,
        input  in_ready, out_valid, zx, nx, zy, ny, f, no, a_sel, is_a_instr,
               a_imm, load_a, load_d, write_m, jump, trap
    );
endinterface

// File: rtl/hack_ctrl_decoder_jump_eval.sv
// -----------------------------------------------------------------------------
// hack_ctrl_decoder_jump_eval
// Combinational jump-condition evaluation from the jump field and ALU flags.
//   jcode in 3  {j1,j2,j3}
//   zr    in 1  ALU result zero
//   ng    in 1  ALU result negative
//   taken out 1 (j1&ng)|(j2&zr)|(j3&~zr&~ng)
// -----------------------------------------------------------------------------
module hack_ctrl_decoder_jump_eval (
    input  logic [2:0] jcode,
    input  logic       zr,
    input  logic       ng,
    output logic       taken
);
    assign taken = (jcode[2] & ng) | (jcode[1] & zr) | (jcode[0] & ~zr & ~ng);
endmodule

// File: rtl/hack_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// hack_ctrl_decoder
// One-entry registered decode stage for Hack instructions. Produces ALU
// controls, destination enables and the jump decision for the held entry,
// and discards KILL_SLOTS accepted instructions after a taken jump.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of hack_ctrl_decoder_if (instr in, controls out)
// Parameters:
//   KILL_SLOTS  instructions discarded after a taken jump (0..3)
// Build option:
//   ILLEGAL_TRAP_EN  when defined, a loadable C-instruction with
//                    instr[14:13]!=2'b11 is dropped and sets a sticky trap
//                    that closes intake until reset.
// -----------------------------------------------------------------------------
module hack_ctrl_decoder
    import hack_ctrl_decoder_pkg::*;
#(
    parameter int KILL_SLOTS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    hack_ctrl_decoder_if.slave  bus
);

    localparam logic [1:0] KILL_INIT      = 2'(KILL_SLOTS);
    // The accept that coincides with the jump transfer already uses one slot.
    localparam logic [1:0] KILL_AFTER_ACC = (KILL_SLOTS > 0) ? 2'(KILL_SLOTS - 1) : 2'd0;

    state_e     state_r;
    state_e     state_nxt_s;
    dec_t       entry_r;
    logic [1:0] kill_cnt_r;

    logic out_valid_s;
    logic in_ready_s;
    logic accept_s;
    logic xfer_s;
    logic jump_raw_s;
    logic jump_s;
    logic kill_now_s;
    logic illegal_s;
    logic load_s;
    logic trap_set_s;

    hack_ctrl_decoder_jump_eval u_jump_eval (
        .jcode (entry_r.jcode),
        .zr    (bus.alu_zr),
        .ng    (bus.alu_ng),
        .taken (jump_raw_s)
    );

    assign accept_s = bus.in_valid & in_ready_s;
    assign xfer_s   = out_valid_s & bus.out_ready;
    assign jump_s   = jump_raw_s & out_valid_s;

    // A slot is killed while the counter is pending, or in the very cycle a
    // taken jump leaves the stage.
    assign kill_now_s = (kill_cnt_r != 2'd0) |
                        (xfer_s & jump_s & (KILL_INIT != 2'd0));

`ifdef ILLEGAL_TRAP_EN
    assign illegal_s = is_illegal(bus.instr);
`else
    assign illegal_s = 1'b0;
`endif

    assign load_s     = accept_s & ~kill_now_s & ~illegal_s;
    assign trap_set_s = accept_s & ~kill_now_s & illegal_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (trap_set_s) begin
                    state_nxt_s = ST_TRAP;
                end else if (load_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // An accept here always coincides with a transfer.
                if (trap_set_s) begin
                    state_nxt_s = ST_TRAP;
                end else if (load_s) begin
                    state_nxt_s = ST_FULL;
                end else if (xfer_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            ST_TRAP: begin
                state_nxt_s = ST_TRAP;
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        out_valid_s = 1'b0;
        in_ready_s  = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                in_ready_s = 1'b1;
            end
            ST_FULL: begin
                out_valid_s = 1'b1;
                in_ready_s  = bus.out_ready;
            end
            ST_TRAP: begin
                in_ready_s = 1'b0;
            end
            default: begin
                in_ready_s = 1'b0;
            end
        endcase
    end

    // Entry register: load on a kept accept, clear when drained without refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_r <= '0;
        end else if (load_s) begin
            entry_r <= decode(bus.instr);
        end else if (xfer_s) begin
            entry_r <= '0;
        end
    end

    // Kill counter: armed by a taken-jump transfer, consumed per accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_cnt_r <= 2'd0;
        end else if (xfer_s & jump_s) begin
            kill_cnt_r <= accept_s ? KILL_AFTER_ACC : KILL_INIT;
        end else if (accept_s & (kill_cnt_r != 2'd0)) begin
            kill_cnt_r <= kill_cnt_r - 2'd1;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_s;
    assign bus.zx         = entry_r.alu[5];
    assign bus.nx         = entry_r.alu[4];
    assign bus.zy         = entry_r.alu[3];
    assign bus.ny         = entry_r.alu[2];
    assign bus.f          = entry_r.alu[1];
    assign bus.no         = entry_r.alu[0];
    assign bus.a_sel      = entry_r.a_sel;
    assign bus.is_a_instr = entry_r.is_a;
    assign bus.a_imm      = entry_r.a_imm;
    assign bus.load_a     = entry_r.load_a;
    assign bus.load_d     = entry_r.load_d;
    assign bus.write_m    = entry_r.write_m;
    assign bus.jump       = jump_s;

`ifdef ILLEGAL_TRAP_EN
    assign bus.trap = (state_r == ST_TRAP);
`else
    assign bus.trap = 1'b0;
`endif

endmodule
